impact_sram_ctrl: RTL and testbench



---
 rtl/impact_sram_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_impact_sram_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/impact_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : impact_sram_ctrl
// Description : Request sequencer for one 32x16 IMPACT SRAM bank. It runs the
//               precharge, word-line and recovery phases and then presents
//               the response. Defining IMPACT_CTRL_VERIFY_EN adds a read-back
//               verify pass after every write.
// Revision    : 1.0 - initial release
// ============================================================================
module impact_sram_ctrl #(
  parameter int unsigned PRE_CYC = 2,
  parameter int unsigned WL_CYC  = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_row,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  wl_sel,
  output logic        pch_en,
  output logic        bl_oe,
  output logic [15:0] bl_out,
  output logic [15:0] blb_out,
  input  logic [15:0] bl_in
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_PRE  = 3'd1;
  localparam logic [2:0] c_ACT  = 3'd2;
  localparam logic [2:0] c_REC  = 3'd3;
  localparam logic [2:0] c_RESP = 3'd4;
`ifdef IMPACT_CTRL_VERIFY_EN
  localparam logic [2:0] c_VPRE = 3'd5;
  localparam logic [2:0] c_VACT = 3'd6;
`endif

  // Decoder code with the row-enable field all ones selects no word line.
  localparam logic [9:0] c_WL_PARK = 10'h3E0;
  localparam logic [3:0] c_PRE_LD  = 4'(PRE_CYC);
  localparam logic [3:0] c_WL_LD   = 4'(WL_CYC);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [4:0]  r_row;
  logic [15:0] r_wdata;
  logic [9:0]  r_wl_sel;
  logic        r_pch_en;
  logic        r_bl_oe;
  logic [15:0] r_bl_out;
  logic [15:0] r_blb_out;
  logic        r_resp_valid;
  logic [15:0] r_rdata;
`ifdef IMPACT_CTRL_VERIFY_EN
  logic        r_err;
`endif

  logic w_last;
  assign w_last = (r_cnt <= 4'd1);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_row        <= '0;
      r_wdata      <= '0;
      r_wl_sel     <= c_WL_PARK;
      r_pch_en     <= 1'b0;
      r_bl_oe      <= 1'b0;
      r_bl_out     <= '0;
      r_blb_out    <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
`ifdef IMPACT_CTRL_VERIFY_EN
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_row    <= req_row;
            r_wdata  <= req_wdata;
            r_state  <= c_PRE;
            r_cnt    <= c_PRE_LD;
            r_pch_en <= 1'b1;
          end
        end
        c_PRE: begin
          if (w_last) begin
            r_state   <= c_ACT;
            r_cnt     <= c_WL_LD;
            r_pch_en  <= 1'b0;
            r_wl_sel  <= {5'b0, r_row};
            r_bl_oe   <= r_we;
            r_bl_out  <= r_we ? r_wdata : '0;
            r_blb_out <= r_we ? ~r_wdata : '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_ACT: begin
          if (w_last) begin
            r_wl_sel  <= c_WL_PARK;
            r_bl_oe   <= 1'b0;
            r_bl_out  <= '0;
            r_blb_out <= '0;
            if (r_we) begin
`ifdef IMPACT_CTRL_VERIFY_EN
              r_state  <= c_VPRE;
              r_cnt    <= c_PRE_LD;
              r_pch_en <= 1'b1;
`else
              r_state  <= c_REC;
`endif
            end else begin
              r_state <= c_REC;
              r_rdata <= bl_in;
`ifdef IMPACT_CTRL_VERIFY_EN
              r_err   <= 1'b0;
`endif
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`ifdef IMPACT_CTRL_VERIFY_EN
        c_VPRE: begin
          if (w_last) begin
            r_state  <= c_VACT;
            r_cnt    <= c_WL_LD;
            r_pch_en <= 1'b0;
            r_wl_sel <= {5'b0, r_row};
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_VACT: begin
          // Read-back pass: the sensed word is both the result and the verify sample.
          if (w_last) begin
            r_state  <= c_REC;
            r_wl_sel <= c_WL_PARK;
            r_rdata  <= bl_in;
            r_err    <= (bl_in != r_wdata);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`endif
        c_REC: begin
          r_state      <= c_RESP;
          r_resp_valid <= 1'b1;
        end
        c_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == c_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
`ifdef IMPACT_CTRL_VERIFY_EN
  assign resp_err   = r_err;
`else
  assign resp_err   = 1'b0;
`endif
  assign wl_sel     = r_wl_sel;
  assign pch_en     = r_pch_en;
  assign bl_oe      = r_bl_oe;
  assign bl_out     = r_bl_out;
  assign blb_out    = r_blb_out;

endmodule
`default_nettype wire

// File: tb/tb_impact_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_impact_sram_ctrl
// Description : Randomised scoreboard bench for impact_sram_ctrl with an SRAM
//               bitline model; honours IMPACT_CTRL_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_impact_sram_ctrl;

  localparam int P = 2;
  localparam int W = 2;
`ifdef IMPACT_CTRL_VERIFY_EN
  localparam bit          VERIFY = 1'b1;
  localparam logic [15:0] MASK   = 16'hFFFE;  // bit 0 of the array reads stuck-at-0
`else
  localparam bit          VERIFY = 1'b0;
  localparam logic [15:0] MASK   = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [4:0]  req_row = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  wl_sel;
  logic        pch_en;
  logic        bl_oe;
  logic [15:0] bl_out;
  logic [15:0] blb_out;
  logic [15:0] bl_in;

  impact_sram_ctrl #(.PRE_CYC(P), .WL_CYC(W)) dut (
    .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_row(req_row), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wl_sel(wl_sel), .pch_en(pch_en), .bl_oe(bl_oe),
    .bl_out(bl_out), .blb_out(blb_out), .bl_in(bl_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  row;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          hs;
  } op_t;

  op_t         q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          in_reset = 1'b1;
  bit          sram_load = 1'b1;
  bit          prev_v = 1'b0;
  bit          rr_rand = 1'b0;
  logic [15:0] held_rd;
  logic        held_err;
  logic [15:0] sram [32];
  logic [15:0] ref_mem [32];
  logic [15:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    return (i == 31) ? 16'h1234 : 16'(i * 40503 + 777);
  endfunction

  // Bank model: driven bitlines write the selected row, otherwise a selected
  // row is sensed; with no row selected the bitlines sit precharged high.
  always @(posedge clk) begin
    if (sram_load) begin
      for (int i = 0; i < 32; i++) sram[i] <= init_val(i);
    end else if (bl_oe && wl_sel[9:5] == 5'd0) begin
      sram[wl_sel[4:0]] <= bl_out;
    end
  end
  assign bl_in = (wl_sel[9:5] == 5'd0 && !bl_oe) ? (sram[wl_sel[4:0]] & MASK) : 16'hFFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {pch_en, bl_oe, wl_sel, bl_out, blb_out} in cycle k after the handshake.
  function automatic logic [43:0] exp_phase(input op_t o, input int k);
    bit pre, act, vpre, vact, oe;
    logic [15:0] bo;
    pre  = (k >= 1) && (k <= P);
    act  = (k >= P + 1) && (k <= P + W);
    vpre = VERIFY && o.we && (k >= P + W + 1) && (k <= 2 * P + W);
    vact = VERIFY && o.we && (k >= 2 * P + W + 1) && (k <= 2 * P + 2 * W);
    oe   = o.we && act;
    bo   = oe ? o.wdata : 16'h0;
    return {pre | vpre, oe, (act | vact) ? {5'b0, o.row} : 10'h3E0, bo, oe ? ~bo : 16'h0};
  endfunction

  // Monitor: per-cycle phase checks plus response scoreboard.
  initial begin
    op_t o;
    logic [43:0] e;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        e = {2'b00, 10'h3E0, 32'h0};
        if (q.size() > 0) e = exp_phase(q[0], cyc - q[0].hs);
        chk("phase{pch,oe,wl,bl,blb}", 64'({pch_en, bl_oe, wl_sel, bl_out, blb_out}), 64'(e));
        if (resp_valid && !prev_v) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", 64'(resp_valid), 64'(0));
          end else begin
            o = q.pop_front();
            chk("resp_rdata", 64'(resp_rdata), 64'(o.rdata));
            chk("resp_err", 64'(resp_err), 64'(o.err));
            chk("resp_latency", 64'(cyc - o.hs), 64'(o.lat));
            held_rd  = o.rdata;
            held_err = o.err;
          end
        end else if (resp_valid && prev_v) begin
          chk("resp_hold{rdata,err,req_ready}", 64'({resp_rdata, resp_err, req_ready}),
              64'({held_rd, held_err, 1'b0}));
        end
        prev_v = resp_valid;
      end
    end
  end

  task automatic issue(input logic we, input logic [4:0] row, input logic [15:0] wd);
    op_t o;
    int  n;
    o.we = we; o.row = row; o.wdata = wd;
    if (!we) begin
      o.rdata = ref_mem[row] & MASK;
      o.err   = 1'b0;
      o.lat   = P + W + 2;
      last_rd = o.rdata;
    end else begin
      ref_mem[row] = wd;
      if (VERIFY) begin
        o.rdata = wd & MASK;
        o.err   = (o.rdata != wd);
        o.lat   = 2 * P + 2 * W + 2;
        last_rd = o.rdata;
      end else begin
        o.rdata = last_rd;
        o.err   = 1'b0;
        o.lat   = P + W + 2;
      end
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_row = row; req_wdata = wd;
    n = 0;
    while (!req_ready) begin
      n++;
      if (n > 200) begin
        chk("handshake_timeout", 64'(0), 64'(1));
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    o.hs = cyc;
    q.push_back(o);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    chk(name, 64'({wl_sel, pch_en, bl_oe, resp_valid, req_ready, resp_rdata, resp_err}),
        64'({10'h3E0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0}));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() > 0 || resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    sram_load = 1'b0;
    wb_rst_ni = 1'b1;
    @(negedge clk);
    check_reset_state("reset_state");
    in_reset = 1'b0;
    resp_ready = 1'b1;

    issue(1'b1, 5'd5, 16'hA5C3);
    issue(1'b0, 5'd31, 16'h0);
    issue(1'b0, 5'd5, 16'h0);

    // Reset asserted for three cycles in the first word-line cycle of a write.
    issue(1'b1, 5'd12, 16'h3C3C);
    n = 0;
    while (q.size() > 0 && (cyc - q[0].hs) < P + 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_reset = 1'b1;
    wb_rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    q.delete();
    prev_v = 1'b0;
    last_rd = '0;
    wb_rst_ni = 1'b1;
    @(negedge clk);
    check_reset_state("reset_mid_act");
    in_reset = 1'b0;
    issue(1'b0, 5'd12, 16'h0);

    // Backpressure: response held 10 cycles while the next request waits.
    issue(1'b0, 5'd3, 16'h0);
    resp_ready = 1'b0;
    fork
      issue(1'b1, 5'd9, 16'hBEEF);
      begin
        n = 0;
        while (!resp_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (10) @(negedge clk);
        resp_ready = 1'b1;
      end
    join
    issue(1'b0, 5'd9, 16'h0);

    // Verify-pass patterns (stuck bit 0 in the verify build).
    issue(1'b1, 5'd7, 16'h0001);
    issue(1'b1, 5'd7, 16'h0002);
    issue(1'b0, 5'd7, 16'h0);

    rr_rand = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++)
          issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
        wait_drain();
        rr_rand = 1'b0;
      end
      begin
        while (rr_rand) begin
          @(negedge clk);
          resp_ready = 1'($urandom_range(0, 1));
        end
        resp_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
